wb_commit_stage: RTL

WB_COMMIT_STAGE -- requirements
Module: wb_commit_stage

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/load_align.sv | 46 ++++
 rtl/wb_commit_stage.sv | 137 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the writeback/commit path: result-source select,
// load-size codes, commit FSM states and the latched load-format record.
package riscv_pkg;

    typedef enum logic [2:0] {
        WB_ALU   = 3'd0,
        WB_MEM   = 3'd1,
        WB_LINK  = 3'd2,
        WB_IMM   = 3'd3,
        WB_PCOFF = 3'd4
    } wb_sel_e;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } state_e;

    typedef struct packed {
        logic [4:0] rd;
        ld_size_e   size;
        logic       uns;
        logic [2:0] offset;
    } ld_meta_t;

endpackage

// File: rtl/load_align.sv
// Load data formatter: picks the addressed lane of the returned word and sign/zero extends it.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module load_align
    import riscv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] i_data,
    input  logic [1:0]   i_size,
    input  logic         i_unsigned,
    input  logic [2:0]   i_offset,
    output logic [N-1:0] o_data
);

    localparam logic [2:0] LANE_MASK = 3'(N/8 - 1);

    ld_size_e     w_size;
    logic [2:0]   w_lane;
    logic [N-1:0] w_sh;

    always_comb begin
        w_size = ld_size_e'(i_size);
        // A doubleword on a 32-bit datapath degenerates to a word load.
        if (N == 32 && w_size == LD_D) begin
            w_size = LD_W;
        end

        case (w_size)
            LD_B:    w_lane = i_offset;
            LD_H:    w_lane = {i_offset[2:1], 1'b0};
            LD_W:    w_lane = {i_offset[2], 2'b00};
            default: w_lane = 3'b000;
        endcase
        w_lane = w_lane & LANE_MASK;
        w_sh   = i_data >> {w_lane, 3'b000};

        case (w_size)
            LD_B:    o_data = i_unsigned ? N'(w_sh[7:0])  : N'($signed(w_sh[7:0]));
            LD_H:    o_data = i_unsigned ? N'(w_sh[15:0]) : N'($signed(w_sh[15:0]));
            LD_W:    o_data = i_unsigned ? N'(w_sh[31:0]) : N'($signed(w_sh[31:0]));
            default: o_data = w_sh;
        endcase
    end

endmodule

// File: rtl/wb_commit_stage.sv
// Writeback/commit: selects the result, waits for load data, writes the RF and counts retirements.
// Latency: one cycle from accept (or from mem_rvalid for loads) to rf_we.
// Backpressure: in_ready drops while a load is outstanding, during flush and in reset.
module wb_commit_stage
    import riscv_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     alu_out,
    input  logic [N-1:0]     return_addr,
    input  logic [N-1:0]     imm_out,
    input  logic [N-1:0]     pc_signed_offset,
    input  logic [2:0]       wb_sel,
    input  logic [4:0]       rd,
    input  logic [1:0]       ld_size,
    input  logic             ld_unsigned,
    input  logic [2:0]       ld_offset,
    input  logic             mem_rvalid,
    input  logic [N-1:0]     mem_rdata,
    input  logic             flush,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [N-1:0]     rf_wdata,
    output logic             fwd_valid,
    output logic [4:0]       fwd_addr,
    output logic [N-1:0]     fwd_data,
    output logic [CNT_W-1:0] instret
);

    state_e           r_state;
    state_e           w_state_nxt;
    ld_meta_t         r_ld;
    logic             r_rdy;
    logic             r_we;
    logic [4:0]       r_waddr;
    logic [N-1:0]     r_wdata;
    logic [CNT_W-1:0] r_instret;

    logic             w_accept;
    logic             w_commit;
    logic             w_ld_latch;
    logic [4:0]       w_caddr;
    logic [N-1:0]     w_cdata;
    logic [N-1:0]     w_src;
    logic [N-1:0]     w_ld_data;

    // r_rdy is low through reset and comes up on the first edge after release.
    assign in_ready = r_rdy & ~flush;
    assign w_accept = in_valid & in_ready;

    load_align #(.N(N)) u_load_align (
        .i_data     (mem_rdata),
        .i_size     (r_ld.size),
        .i_unsigned (r_ld.uns),
        .i_offset   (r_ld.offset),
        .o_data     (w_ld_data)
    );

    always_comb begin
        case (wb_sel_e'(wb_sel))
            WB_LINK:  w_src = return_addr;
            WB_IMM:   w_src = imm_out;
            WB_PCOFF: w_src = pc_signed_offset;
            default:  w_src = alu_out;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_ld_latch  = 1'b0;
        w_caddr     = rd;
        w_cdata     = w_src;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (wb_sel_e'(wb_sel) == WB_MEM) begin
                        w_ld_latch  = 1'b1;
                        w_state_nxt = ST_WAIT_MEM;
                    end else begin
                        w_commit = 1'b1;
                    end
                end
            end
            ST_WAIT_MEM: begin
                // Flush wins over a load return arriving in the same cycle.
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                end else if (mem_rvalid) begin
                    w_commit    = 1'b1;
                    w_caddr     = r_ld.rd;
                    w_cdata     = w_ld_data;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rdy     <= 1'b0;
            r_ld      <= '0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_instret <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rdy   <= (w_state_nxt == ST_IDLE);
            if (w_ld_latch) begin
                r_ld <= '{rd: rd, size: ld_size_e'(ld_size), uns: ld_unsigned, offset: ld_offset};
            end
            r_we <= w_commit & (w_caddr != 5'd0);
            if (w_commit) begin
                r_waddr   <= w_caddr;
                r_wdata   <= w_cdata;
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    assign rf_we     = r_we;
    assign rf_waddr  = r_waddr;
    assign rf_wdata  = r_wdata;
    assign fwd_valid = r_we;
    assign fwd_addr  = r_waddr;
    assign fwd_data  = r_wdata;
    assign instret   = r_instret;

endmodule
